conv_array_feeder: RTL

Source side of the convolution kernel array interface. Loads nine 3x3 kernel weights plus a bias, buffers three image rows in a sliding line buffer, and drives the array with the state code, the per-cycle weight, and the shifted `ARRAY_SIZE`-pixel window. One output row of `ARRAY_SIZE` convolution results is produced per ROW_0..BIAS pass. The block sits between the image/weight memories and the kernel array, and is the sole generator of `current_state`.

---
 rtl/conv_array_feeder_if.sv | 34 +++
 rtl/conv_array_feeder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/conv_array_feeder_if.sv
// Handshake and array-facing signals of conv_array_feeder.
// The feeder takes the master modport and the memories/array side takes the slave modport.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface conv_array_feeder_if #(
    parameter int DW         = `DATA_WIDTH,
    parameter int IMAGE_SIZE = 8,
    parameter int ARRAY_SIZE = 6
);
    logic                       i_weight_valid;
    logic [DW-1:0]              i_weight_data;
    logic                       o_weight_ready;
    logic                       i_row_valid;
    logic [IMAGE_SIZE*DW-1:0]   i_row_data;
    logic                       o_row_ready;
    logic [2:0]                 o_current_state;
    logic [ARRAY_SIZE*DW-1:0]   o_pixel_bus;
    logic [DW-1:0]              o_weight;
    logic [2:0]                 o_out_row;

    modport master (
        input  i_weight_valid, i_weight_data, i_row_valid, i_row_data,
        output o_weight_ready, o_row_ready, o_current_state, o_pixel_bus,
        o_weight, o_out_row
    );

    modport slave (
        output i_weight_valid, i_weight_data, i_row_valid, i_row_data,
        input  o_weight_ready, o_row_ready, o_current_state, o_pixel_bus,
        o_weight, o_out_row
    );
endinterface

// File: rtl/conv_array_feeder.sv
// Source side of the 3x3 convolution array: loads weights and bias, keeps a
// three-row sliding line buffer, and drives state code, weight and pixel window.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module conv_array_feeder #(
    parameter int                      KERNEL_SIZE = 3,
    parameter int                      IMAGE_SIZE  = 8,
    parameter int                      ARRAY_SIZE  = 6,
    parameter logic [`DATA_WIDTH-1:0]  ONE_VALUE   = 32'h3F800000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    conv_array_feeder_if.master   bus,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam int DW = `DATA_WIDTH;
    localparam int RW = IMAGE_SIZE * DW;
    localparam int PW = ARRAY_SIZE * DW;
    localparam int NW = KERNEL_SIZE * KERNEL_SIZE + 1;

    localparam logic [2:0] S_INIT    = 3'd0;
    localparam logic [2:0] S_PRELOAD = 3'd1;
    localparam logic [2:0] S_ROW_0   = 3'd2;
    localparam logic [2:0] S_ROW_1   = 3'd3;
    localparam logic [2:0] S_ROW_2   = 3'd4;
    localparam logic [2:0] S_BIAS    = 3'd5;
    localparam logic [2:0] S_LOAD    = 3'd6;
    localparam logic [2:0] S_IDLE    = 3'd7;

    logic [2:0]    state, nxt_state;
    logic [3:0]    widx, nxt_widx;
    logic [1:0]    lidx, nxt_lidx;
    logic [1:0]    j, nxt_j;
    logic [2:0]    out_row, nxt_out_row;
    logic [DW-1:0] w_mem [NW];
    logic [DW-1:0] nxt_w [NW];
    logic [RW-1:0] line_buf [3];
    logic [RW-1:0] nxt_buf [3];
    logic [PW-1:0] pixel_bus, nxt_pix;
    logic [DW-1:0] weight, nxt_weight;
    logic          done, nxt_done;
    logic          row_beat;
    logic [1:0]    row_k;
    logic [RW-1:0] win_src;

    assign bus.o_weight_ready  = (state == S_INIT);
    assign bus.o_row_ready     = (state == S_PRELOAD) || (state == S_LOAD);
    assign bus.o_current_state = state;
    assign bus.o_pixel_bus     = pixel_bus;
    assign bus.o_weight        = weight;
    assign bus.o_out_row       = out_row;
    assign o_busy              = (state != S_IDLE);
    assign o_done              = done;
    assign row_beat            = bus.i_row_valid && bus.o_row_ready;

    always_comb begin
        nxt_state   = state;
        nxt_widx    = widx;
        nxt_lidx    = lidx;
        nxt_j       = j;
        nxt_out_row = out_row;
        nxt_done    = 1'b0;
        nxt_w       = w_mem;
        nxt_buf     = line_buf;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    nxt_state   = S_INIT;
                    nxt_widx    = '0;
                    nxt_lidx    = '0;
                    nxt_j       = '0;
                    nxt_out_row = '0;
                end
            end
            S_INIT: begin
                if (bus.i_weight_valid) begin
                    nxt_w[widx] = bus.i_weight_data;
                    nxt_widx    = widx + 4'd1;
                    if (widx == 4'(NW - 1)) nxt_state = S_PRELOAD;
                end
            end
            S_PRELOAD: begin
                if (row_beat) begin
                    nxt_buf[lidx] = bus.i_row_data;
                    nxt_lidx      = lidx + 2'd1;
                    if (lidx == 2'(KERNEL_SIZE - 1)) begin
                        nxt_state = S_ROW_0;
                        nxt_j     = '0;
                    end
                end
            end
            S_ROW_0, S_ROW_1, S_ROW_2: begin
                if (j == 2'(KERNEL_SIZE - 1)) begin
                    nxt_j     = '0;
                    nxt_state = state + 3'd1;  // ROW_2 + 1 is BIAS
                end else begin
                    nxt_j = j + 2'd1;
                end
            end
            S_BIAS: begin
                if (out_row == 3'(ARRAY_SIZE - 1)) begin
                    nxt_state = S_IDLE;
                    nxt_done  = 1'b1;
                end else begin
                    nxt_out_row = out_row + 3'd1;
                    nxt_state   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (row_beat) begin
                    nxt_buf[0] = line_buf[1];
                    nxt_buf[1] = line_buf[2];
                    nxt_buf[2] = bus.i_row_data;
                    nxt_state  = S_ROW_0;
                    nxt_j      = '0;
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    // Window is built from next-state values so it is registered alongside the state code.
    always_comb begin
        nxt_pix    = '0;
        nxt_weight = '0;
        row_k      = 2'(nxt_state - S_ROW_0);
        win_src    = '0;
        if ((nxt_state == S_ROW_0) || (nxt_state == S_ROW_1) || (nxt_state == S_ROW_2)) begin
            win_src    = nxt_buf[row_k] << (32'(nxt_j) * DW);
            nxt_pix    = win_src[RW-1 -: PW];
            nxt_weight = nxt_w[4'(row_k) * 4'(KERNEL_SIZE) + 4'(nxt_j)];
        end else if (nxt_state == S_BIAS) begin
            nxt_pix    = {ARRAY_SIZE{ONE_VALUE}};
            nxt_weight = nxt_w[NW-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            widx      <= '0;
            lidx      <= '0;
            j         <= '0;
            out_row   <= '0;
            pixel_bus <= '0;
            weight    <= '0;
            done      <= 1'b0;
            for (int unsigned n = 0; n < NW; n++) w_mem[n] <= '0;
            for (int unsigned n = 0; n < 3; n++) line_buf[n] <= '0;
        end else begin
            state     <= nxt_state;
            widx      <= nxt_widx;
            lidx      <= nxt_lidx;
            j         <= nxt_j;
            out_row   <= nxt_out_row;
            pixel_bus <= nxt_pix;
            weight    <= nxt_weight;
            done      <= nxt_done;
            w_mem     <= nxt_w;
            line_buf  <= nxt_buf;
        end
    end
endmodule
